// File: rtl/dsp_pkg.sv
// Shared constants and helpers for the wb_dsp_system core: bus widths,
// the register address map and CONTROL bit positions.
package dsp_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] MEM_BASE    = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DSP_CONTROL = 32'h0000_1000;
  localparam logic [ADDR_W-1:0] DSP_A       = 32'h0000_1004;
  localparam logic [ADDR_W-1:0] DSP_B       = 32'h0000_1008;
  localparam logic [ADDR_W-1:0] DSP_RESULT  = 32'h0000_100C;
  localparam logic [ADDR_W-1:0] DSP_STATUS  = 32'h0000_1010;
  localparam logic [ADDR_W-1:0] DSP_DTB     = 32'h0000_1014;

  localparam int CTRL_GO_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic {M_IDLE, M_BUS} master_state_e;
  typedef enum logic {GNT_CPU, GNT_DAQ} grant_e;

  // Replace only the bytes whose enable bit is set.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [3:0]        sel);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        r[i*8 +: 8] = new_w[i*8 +: 8];
      end else begin
        r[i*8 +: 8] = old_w[i*8 +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// Turns a one-cycle start command into a single Wishbone transaction and
// returns read data; instantiated once per command port.
module wb_cmd_master
  import dsp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        selection,
  input  logic              write,
  input  logic [DATA_W-1:0] data_wr,
  output logic [DATA_W-1:0] data_rd,
  output logic              active,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i
);

  master_state_e     state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] rd_q, rd_d;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    dat_d   = dat_q;
    rd_d    = rd_q;
    case (state_q)
      M_IDLE: begin
        if (start) begin
          state_d = M_BUS;
          adr_d   = address;
          sel_d   = selection;
          we_d    = write;
          dat_d   = data_wr;
        end else begin
          state_d = M_IDLE;
        end
      end
      M_BUS: begin
        if (wb_ack_i) begin
          state_d = M_IDLE;
          if (!we_q) begin
            rd_d = wb_dat_i;
          end else begin
            rd_d = rd_q;
          end
        end else begin
          state_d = M_BUS;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= M_IDLE;
      adr_q   <= 32'h0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      dat_q   <= 32'h0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      rd_q    <= rd_d;
    end
  end

  assign active   = (state_q == M_BUS);
  assign wb_cyc_o = (state_q == M_BUS);
  assign wb_stb_o = (state_q == M_BUS);
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = dat_q;
  assign data_rd  = rd_q;

endmodule

// File: rtl/wb_dsp_system.sv
// Wishbone core: two command masters, fixed-priority arbiter, SRAM and DSP
// MAC register slaves, file FIFO side port and debug test bus.
module wb_dsp_system
  import dsp_pkg::*;
#(
  parameter int MEM_WORDS  = 256,
  parameter int FILE_DEPTH = 8,
  parameter int NUM_FILES  = 4
) (
  input  logic              clk_pad_i,
  input  logic              rst_pad_i,
  input  logic              cpu_start,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [3:0]        cpu_selection,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_data_wr,
  output logic [DATA_W-1:0] cpu_data_rd,
  output logic              cpu_active,
  input  logic              daq_start,
  input  logic [ADDR_W-1:0] daq_address,
  input  logic [3:0]        daq_selection,
  input  logic              daq_write,
  input  logic [DATA_W-1:0] daq_data_wr,
  output logic [DATA_W-1:0] daq_data_rd,
  output logic              daq_active,
  input  logic [7:0]        file_num,
  input  logic              file_write,
  input  logic [DATA_W-1:0] file_write_data,
  input  logic              file_read,
  output logic [DATA_W-1:0] file_read_data,
  output logic              file_active,
  output logic [DATA_W-1:0] dtb_pad
);

  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam int FP_W   = $clog2(FILE_DEPTH);
  localparam int CNT_W  = FP_W + 1;
  localparam int FSEL_W = $clog2(NUM_FILES);

  logic clk, rst;
  assign clk = clk_pad_i;
  assign rst = rst_pad_i;

  logic              cpu_cyc_s, cpu_stb_s, cpu_we_s, cpu_ack_s;
  logic [ADDR_W-1:0] cpu_adr_s;
  logic [3:0]        cpu_sel_s;
  logic [DATA_W-1:0] cpu_dat_s;
  logic              daq_cyc_s, daq_stb_s, daq_we_s, daq_ack_s;
  logic [ADDR_W-1:0] daq_adr_s;
  logic [3:0]        daq_sel_s;
  logic [DATA_W-1:0] daq_dat_s;

  logic              bus_stb_s, bus_we_s, bus_req_s;
  logic [ADDR_W-1:0] bus_adr_s;
  logic [3:0]        bus_sel_s;
  logic [DATA_W-1:0] bus_wdat_s;

  grant_e            gnt_s, owner_q, owner_d;
  logic              lock_q, lock_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  wb_cmd_master u_cpu (
    .clk(clk), .rst(rst), .start(cpu_start), .address(cpu_address),
    .selection(cpu_selection), .write(cpu_write), .data_wr(cpu_data_wr),
    .data_rd(cpu_data_rd), .active(cpu_active),
    .wb_cyc_o(cpu_cyc_s), .wb_stb_o(cpu_stb_s), .wb_we_o(cpu_we_s),
    .wb_adr_o(cpu_adr_s), .wb_sel_o(cpu_sel_s), .wb_dat_o(cpu_dat_s),
    .wb_dat_i(rdata_q), .wb_ack_i(cpu_ack_s)
  );

  wb_cmd_master u_daq (
    .clk(clk), .rst(rst), .start(daq_start), .address(daq_address),
    .selection(daq_selection), .write(daq_write), .data_wr(daq_data_wr),
    .data_rd(daq_data_rd), .active(daq_active),
    .wb_cyc_o(daq_cyc_s), .wb_stb_o(daq_stb_s), .wb_we_o(daq_we_s),
    .wb_adr_o(daq_adr_s), .wb_sel_o(daq_sel_s), .wb_dat_o(daq_dat_s),
    .wb_dat_i(rdata_q), .wb_ack_i(daq_ack_s)
  );

  // Grant is frozen from the first strobe until its ack; CPU wins when free.
  always_comb begin
    if (lock_q) begin
      gnt_s = owner_q;
    end else if (cpu_cyc_s) begin
      gnt_s = GNT_CPU;
    end else begin
      gnt_s = GNT_DAQ;
    end
    if (gnt_s == GNT_CPU) begin
      bus_stb_s  = cpu_stb_s;
      bus_we_s   = cpu_we_s;
      bus_adr_s  = cpu_adr_s;
      bus_sel_s  = cpu_sel_s;
      bus_wdat_s = cpu_dat_s;
    end else begin
      bus_stb_s  = daq_stb_s;
      bus_we_s   = daq_we_s;
      bus_adr_s  = daq_adr_s;
      bus_sel_s  = daq_sel_s;
      bus_wdat_s = daq_dat_s;
    end
    if (ack_q) begin
      lock_d = 1'b0;
    end else if (bus_stb_s) begin
      lock_d = 1'b1;
    end else begin
      lock_d = lock_q;
    end
    owner_d   = gnt_s;
    cpu_ack_s = ack_q && (gnt_s == GNT_CPU);
    daq_ack_s = ack_q && (gnt_s == GNT_DAQ);
  end

  // The strobe still stands during its ack cycle; only its first cycle counts.
  assign bus_req_s = bus_stb_s && !ack_q;

  logic [DATA_W-1:0] sram_q [MEM_WORDS];
  logic [MEM_AW-1:0] sram_idx_s;
  logic              sram_hit_s, sram_we_s;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d, dtb_q, dtb_d;
  logic              done_q, done_d, go_q, go_d, clr_q, clr_d;

  assign sram_idx_s = bus_adr_s[MEM_AW+1:2];
  assign sram_hit_s = (bus_adr_s[ADDR_W-1:2] < 30'(MEM_WORDS));

  // Slave decode, register writes and the deferred MAC update.
  always_comb begin
    ack_d     = bus_req_s;
    rdata_d   = rdata_q;
    sram_we_s = 1'b0;
    a_d       = a_q;
    b_d       = b_q;
    dtb_d     = dtb_q;
    go_d      = 1'b0;
    clr_d     = 1'b0;
    if (bus_req_s) begin
      rdata_d = 32'h0;
      if (sram_hit_s) begin
        if (bus_we_s) begin
          sram_we_s = 1'b1;
        end else begin
          rdata_d = sram_q[sram_idx_s];
        end
      end else begin
        case (bus_adr_s[ADDR_W-1:2])
          DSP_CONTROL[ADDR_W-1:2]: begin
            if (bus_we_s) begin
              go_d  = bus_wdat_s[CTRL_GO_BIT];
              clr_d = bus_wdat_s[CTRL_CLR_BIT];
            end else begin
              rdata_d = 32'h0;
            end
          end
          DSP_A[ADDR_W-1:2]: begin
            if (bus_we_s) a_d = bus_wdat_s;
            else          rdata_d = a_q;
          end
          DSP_B[ADDR_W-1:2]: begin
            if (bus_we_s) b_d = bus_wdat_s;
            else          rdata_d = b_q;
          end
          DSP_RESULT[ADDR_W-1:2]: begin
            if (bus_we_s) rdata_d = 32'h0;
            else          rdata_d = result_q;
          end
          DSP_STATUS[ADDR_W-1:2]: begin
            if (bus_we_s) rdata_d = 32'h0;
            else          rdata_d = {31'h0, done_q};
          end
          DSP_DTB[ADDR_W-1:2]: begin
            if (bus_we_s) dtb_d = byte_merge(dtb_q, bus_wdat_s, bus_sel_s);
            else          rdata_d = dtb_q;
          end
          default: rdata_d = 32'h0;
        endcase
      end
    end else begin
      rdata_d = rdata_q;
    end
    if (clr_q) begin
      result_d = 32'h0;
      done_d   = 1'b0;
    end else if (go_q) begin
      result_d = result_q + a_q * b_q;
      done_d   = 1'b1;
    end else begin
      result_d = result_q;
      done_d   = done_q;
    end
  end

  // Bus, arbiter and DSP register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= GNT_CPU;
      lock_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      result_q <= 32'h0;
      dtb_q    <= 32'h0;
      done_q   <= 1'b0;
      go_q     <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      lock_q   <= lock_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      dtb_q    <= dtb_d;
      done_q   <= done_d;
      go_q     <= go_d;
      clr_q    <= clr_d;
    end
  end

  // SRAM array; contents are not reset.
  always_ff @(posedge clk) begin
    if (sram_we_s) begin
      sram_q[sram_idx_s] <= byte_merge(sram_q[sram_idx_s], bus_wdat_s, bus_sel_s);
    end
  end

  assign dtb_pad = dtb_q;

  logic [DATA_W-1:0] fifo_q [NUM_FILES][FILE_DEPTH];
  logic [FP_W-1:0]   wptr_q [NUM_FILES], wptr_d [NUM_FILES];
  logic [FP_W-1:0]   rptr_q [NUM_FILES], rptr_d [NUM_FILES];
  logic [CNT_W-1:0]  cnt_q  [NUM_FILES], cnt_d  [NUM_FILES];
  logic [FSEL_W-1:0] fsel_s;
  logic              fvalid_s, push_s, pop_s;
  logic [DATA_W-1:0] fread_q, fread_d;
  logic              factive_q, factive_d;

  assign fsel_s   = file_num[FSEL_W-1:0];
  assign fvalid_s = (file_num < 8'(NUM_FILES));

  // FIFO pointer/count update; fullness is judged before any same-cycle pop.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    push_s    = file_write && fvalid_s && (cnt_q[fsel_s] != CNT_W'(FILE_DEPTH));
    pop_s     = file_read && fvalid_s && (cnt_q[fsel_s] != {CNT_W{1'b0}});
    factive_d = file_write || file_read;
    if (push_s) begin
      wptr_d[fsel_s] = wptr_q[fsel_s] + {{(FP_W-1){1'b0}}, 1'b1};
    end else begin
      wptr_d[fsel_s] = wptr_q[fsel_s];
    end
    if (pop_s) begin
      rptr_d[fsel_s] = rptr_q[fsel_s] + {{(FP_W-1){1'b0}}, 1'b1};
    end else begin
      rptr_d[fsel_s] = rptr_q[fsel_s];
    end
    cnt_d[fsel_s] = cnt_q[fsel_s] + CNT_W'(push_s) - CNT_W'(pop_s);
    if (pop_s) begin
      fread_d = fifo_q[fsel_s][rptr_q[fsel_s]];
    end else if (file_read) begin
      fread_d = 32'h0;
    end else begin
      fread_d = fread_q;
    end
  end

  // FIFO control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < NUM_FILES; f++) begin
        wptr_q[f] <= {FP_W{1'b0}};
        rptr_q[f] <= {FP_W{1'b0}};
        cnt_q[f]  <= {CNT_W{1'b0}};
      end
      fread_q   <= 32'h0;
      factive_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      fread_q   <= fread_d;
      factive_q <= factive_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[fsel_s][wptr_q[fsel_s]] <= file_write_data;
    end
  end

  assign file_read_data = fread_q;
  assign file_active    = factive_q;

  logic unused_s;
  assign unused_s = ^{bus_adr_s[1:0]};

endmodule

// File: tb/tb_wb_dsp_system.sv
// Directed bench for wb_dsp_system with a behavioural model and scoreboards.
module tb_wb_dsp_system;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_start = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_address = 32'h0, cpu_data_wr = 32'h0;
  logic [3:0]  cpu_selection = 4'h0;
  logic [31:0] cpu_data_rd;
  logic        cpu_active;
  logic        daq_start = 1'b0, daq_write = 1'b0;
  logic [31:0] daq_address = 32'h0, daq_data_wr = 32'h0;
  logic [3:0]  daq_selection = 4'h0;
  logic [31:0] daq_data_rd;
  logic        daq_active;
  logic [7:0]  file_num = 8'h0;
  logic        file_write = 1'b0, file_read = 1'b0;
  logic [31:0] file_write_data = 32'h0;
  logic [31:0] file_read_data;
  logic        file_active;
  logic [31:0] dtb_pad;

  wb_dsp_system dut (
    .clk_pad_i(clk), .rst_pad_i(rst),
    .cpu_start(cpu_start), .cpu_address(cpu_address), .cpu_selection(cpu_selection),
    .cpu_write(cpu_write), .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd),
    .cpu_active(cpu_active),
    .daq_start(daq_start), .daq_address(daq_address), .daq_selection(daq_selection),
    .daq_write(daq_write), .daq_data_wr(daq_data_wr), .daq_data_rd(daq_data_rd),
    .daq_active(daq_active),
    .file_num(file_num), .file_write(file_write), .file_write_data(file_write_data),
    .file_read(file_read), .file_read_data(file_read_data), .file_active(file_active),
    .dtb_pad(dtb_pad)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  logic [31:0] fexp_q [$];
  logic [31:0] fq [4][$];
  logic [31:0] m_mem [0:255];
  logic [31:0] m_a = 32'h0, m_b = 32'h0, m_res = 32'h0, m_dtb = 32'h0;
  logic        m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    if (adr < 32'h400) m_mem[adr[9:2]] = merge(m_mem[adr[9:2]], dat, sel);
    else begin
      case ({adr[31:2], 2'b00})
        32'h1000: begin
          if (dat[1]) begin m_res = 32'h0; m_done = 1'b0; end
          else if (dat[0]) begin m_res = m_res + m_a * m_b; m_done = 1'b1; end
        end
        32'h1004: m_a = dat;
        32'h1008: m_b = dat;
        32'h1014: m_dtb = merge(m_dtb, dat, sel);
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] adr);
    if (adr < 32'h400) return m_mem[adr[9:2]];
    case ({adr[31:2], 2'b00})
      32'h1004: return m_a;
      32'h1008: return m_b;
      32'h100C: return m_res;
      32'h1010: return {31'h0, m_done};
      32'h1014: return m_dtb;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic op(input bit daq, input bit we, input logic [31:0] adr,
                    input logic [3:0] sel, input logic [31:0] dat, input string tag);
    int n;
    @(posedge clk); #1;
    if (daq) begin
      daq_start = 1'b1; daq_write = we; daq_address = adr; daq_selection = sel; daq_data_wr = dat;
    end else begin
      cpu_start = 1'b1; cpu_write = we; cpu_address = adr; cpu_selection = sel; cpu_data_wr = dat;
    end
    if (we) model_write(adr, sel, dat);
    else exp_q.push_back(model_read(adr));
    @(posedge clk); #1;
    cpu_start = 1'b0; daq_start = 1'b0;
    n = 0;
    while (((daq ? daq_active : cpu_active) === 1'b1) && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk({tag, " active_cycles"}, 32'(n), 32'd2);
    if (!we) chk({tag, " rdata"}, daq ? daq_data_rd : cpu_data_rd, exp_q.pop_front());
  endtask

  task automatic fop(input bit wr, input bit rd, input logic [7:0] num,
                     input logic [31:0] dat, input string tag);
    bit full;
    logic [31:0] e;
    @(posedge clk); #1;
    file_write = wr; file_read = rd; file_num = num; file_write_data = dat;
    full = (num < 8'd4) ? (fq[num[1:0]].size() >= 8) : 1'b1;
    if (rd) begin
      if (num < 8'd4 && fq[num[1:0]].size() > 0) e = fq[num[1:0]].pop_front();
      else e = 32'h0;
      fexp_q.push_back(e);
    end
    if (wr && num < 8'd4 && !full) fq[num[1:0]].push_back(dat);
    @(posedge clk); #1;
    file_write = 1'b0; file_read = 1'b0;
    chk({tag, " active"}, {31'h0, file_active}, 32'd1);
    if (rd) chk({tag, " rdata"}, file_read_data, fexp_q.pop_front());
    @(posedge clk); #1;
    chk({tag, " active_drop"}, {31'h0, file_active}, 32'd0);
  endtask

  initial begin
    int nc, nd;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset cpu_data_rd", cpu_data_rd, 32'h0);
    chk("reset cpu_active", {31'h0, cpu_active}, 32'h0);
    chk("reset daq_data_rd", daq_data_rd, 32'h0);
    chk("reset daq_active", {31'h0, daq_active}, 32'h0);
    chk("reset file_read_data", file_read_data, 32'h0);
    chk("reset file_active", {31'h0, file_active}, 32'h0);
    chk("reset dtb_pad", dtb_pad, 32'h0);

    op(1'b0, 1'b1, 32'h10, 4'hF, 32'h1234_5678, "sram_wr");
    op(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, "sram_rd");
    op(1'b0, 1'b1, 32'h10, 4'h1, 32'hFFFF_FFAA, "sram_wr_b0");
    op(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, "sram_rd_b0");
    op(1'b1, 1'b1, 32'h3FC, 4'hF, 32'hA5A5_0F0F, "daq_wr_top");
    op(1'b1, 1'b0, 32'h3FE, 4'hF, 32'h0, "daq_rd_top");

    // Simultaneous start: CPU write then DAQ read of the same word.
    @(posedge clk); #1;
    cpu_start = 1'b1; cpu_write = 1'b1; cpu_address = 32'h20; cpu_selection = 4'hF; cpu_data_wr = 32'h1;
    daq_start = 1'b1; daq_write = 1'b0; daq_address = 32'h20; daq_selection = 4'hF;
    model_write(32'h20, 4'hF, 32'h1);
    exp_q.push_back(model_read(32'h20));
    @(posedge clk); #1;
    cpu_start = 1'b0; daq_start = 1'b0;
    nc = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_active === 1'b1) nc++;
      if (daq_active === 1'b1) nd++;
      if (cpu_active !== 1'b1 && daq_active !== 1'b1) break;
      @(posedge clk); #1;
    end
    chk("arb cpu_active_cycles", 32'(nc), 32'd2);
    chk("arb daq_active_cycles", 32'(nd), 32'd4);
    chk("arb daq_rdata", daq_data_rd, exp_q.pop_front());

    op(1'b0, 1'b1, 32'h1004, 4'hF, 32'd3, "dsp_a");
    op(1'b0, 1'b1, 32'h1008, 4'hF, 32'd5, "dsp_b");
    op(1'b0, 1'b1, 32'h1000, 4'hF, 32'h1, "dsp_go1");
    op(1'b0, 1'b1, 32'h1000, 4'hF, 32'h1, "dsp_go2");
    op(1'b0, 1'b0, 32'h100C, 4'hF, 32'h0, "dsp_result30");
    op(1'b0, 1'b0, 32'h1010, 4'hF, 32'h0, "dsp_status1");
    op(1'b0, 1'b0, 32'h1000, 4'hF, 32'h0, "dsp_control_rd");
    op(1'b0, 1'b1, 32'h1000, 4'hF, 32'h2, "dsp_clr");
    op(1'b0, 1'b0, 32'h100C, 4'hF, 32'h0, "dsp_result_clr");
    op(1'b0, 1'b0, 32'h1010, 4'hF, 32'h0, "dsp_status_clr");
    op(1'b0, 1'b1, 32'h1004, 4'hF, 32'hFFFF_FFFF, "dsp_a_max");
    op(1'b0, 1'b1, 32'h1008, 4'hF, 32'd2, "dsp_b2");
    op(1'b0, 1'b1, 32'h1000, 4'hF, 32'h1, "dsp_go_wrap");
    op(1'b0, 1'b0, 32'h100C, 4'hF, 32'h0, "dsp_result_wrap");
    op(1'b0, 1'b1, 32'h1000, 4'hF, 32'h3, "dsp_go_clr");
    op(1'b0, 1'b0, 32'h100C, 4'hF, 32'h0, "dsp_result_goclr");
    op(1'b1, 1'b0, 32'h1004, 4'hF, 32'h0, "dsp_a_rd");

    op(1'b0, 1'b1, 32'h1014, 4'hF, 32'hCAFE_F00D, "dtb_wr");
    chk("dtb_pad after write", dtb_pad, m_dtb);
    op(1'b0, 1'b1, 32'h1014, 4'h4, 32'h0012_0000, "dtb_wr_b2");
    chk("dtb_pad byte2", dtb_pad, m_dtb);
    op(1'b0, 1'b0, 32'h1014, 4'hF, 32'h0, "dtb_rd");
    op(1'b0, 1'b1, 32'h2000, 4'hF, 32'hDEAD_BEEF, "unmapped_wr");
    op(1'b0, 1'b0, 32'h2000, 4'hF, 32'h0, "unmapped_rd");

    for (int i = 1; i <= 9; i++) fop(1'b1, 1'b0, 8'd2, 32'(i), "file2_push");
    for (int i = 1; i <= 9; i++) fop(1'b0, 1'b1, 8'd2, 32'h0, "file2_pop");
    fop(1'b0, 1'b1, 8'd1, 32'h0, "file1_empty");
    fop(1'b1, 1'b0, 8'd7, 32'h7777_7777, "file7_ignored_wr");
    fop(1'b0, 1'b1, 8'd3, 32'h0, "file3_after_ignored");
    fop(1'b1, 1'b1, 8'd3, 32'h0000_ABCD, "file3_rw_empty");
    fop(1'b0, 1'b1, 8'd3, 32'h0, "file3_rd_stored");
    fop(1'b1, 1'b0, 8'd0, 32'h0000_0055, "file0_push");

    // Reset in the middle of a CPU transaction.
    @(posedge clk); #1;
    cpu_start = 1'b1; cpu_write = 1'b1; cpu_address = 32'h40; cpu_selection = 4'hF; cpu_data_wr = 32'h9;
    @(posedge clk); #1;
    cpu_start = 1'b0;
    chk("midreset active_before", {31'h0, cpu_active}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midreset active_after", {31'h0, cpu_active}, 32'h0);
    chk("midreset dtb_pad", dtb_pad, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int f = 0; f < 4; f++) fq[f].delete();
    m_a = 32'h0; m_b = 32'h0; m_res = 32'h0; m_dtb = 32'h0; m_done = 1'b0;
    fop(1'b0, 1'b1, 8'd0, 32'h0, "file0_after_reset");
    op(1'b0, 1'b0, 32'h1004, 4'hF, 32'h0, "dsp_a_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_dsp_system.md
Name: wb_dsp_system

Overview:
- Self-contained Wishbone SoC core with two command-driven bus masters (CPU port, DAQ port), a fixed-priority arbiter, a 256-word SRAM slave, a DSP multiply-accumulate register slave, a 4-channel "file" FIFO side port, and a 32-bit debug test bus output (dtb_pad).
- It is the top-level design a simulation harness drives through simple start/active command ports.

Parameters:
- MEM_WORDS, 256, SRAM depth in 32-bit words.
- FILE_DEPTH, 8, entries per file FIFO.
- NUM_FILES, 4, number of file FIFOs.

Ports:
- clk_pad_i  in  1  system clock; all logic on its rising edge.
- rst_pad_i  in  1  asynchronous, active-high reset.
- cpu_start  in  1  one-cycle request pulse; sampled only while cpu_active=0.
- cpu_address  in  32  byte address.
- cpu_selection  in  4  byte enables.
- cpu_write  in  1  1=write, 0=read.
- cpu_data_wr  in  32  write data.
- cpu_data_rd  out  32  read data.
- cpu_active  out  1  transaction in progress.
- daq_start, daq_address, daq_selection, daq_write, daq_data_wr, daq_data_rd, daq_active: identical to the CPU set, for the DAQ master.
- file_num  in  8  FIFO select; bits [1:0] used, values >=NUM_FILES ignored.
- file_write  in  1  push file_write_data.
- file_write_data  in  32  push data.
- file_read  in  1  pop.
- file_read_data  out  32  popped word.
- file_active  out  1  file operation acknowledge.
- dtb_pad  out  32  debug test bus.

Behaviour:
- Reset values: all outputs 0; SRAM contents undefined; DSP registers 0; FIFOs empty.
- Master port sequence:
  - start is sampled at edge N and address, selection, write and data are latched.
  - active=1 from N+1.
  - Wishbone cyc/stb are issued when the arbiter grants.
  - Slaves ack exactly one cycle after stb.
  - data_rd is loaded on ack for reads and holds its value until the next read completes.
  - active falls the cycle after ack.
  - Uncontended transaction: active high for 2 cycles.
  - start while active=1 is ignored.
- Arbiter:
  - Fixed priority, CPU over DAQ.
  - A grant is held until ack; no preemption.
  - Simultaneous start: CPU completes first, then DAQ is granted the cycle after the CPU ack.
- Address map (word aligned, bits [1:0] ignored):
  - 0x0000_0000–0x0000_03FF: SRAM. Byte enables honoured on writes.
  - 0x0000_1000 CONTROL (W): bit0 GO, bit1 CLR; self-clearing, reads 0.
  - 0x0000_1004 A (R/W).
  - 0x0000_1008 B (R/W).
  - 0x0000_100C RESULT (RO).
  - 0x0000_1010 STATUS (RO): bit0 DONE.
  - 0x0000_1014 DTB (R/W): drives dtb_pad directly. Byte enables honoured.
  - Any other address: acked normally, reads return 0, writes discarded.
- DSP:
  - GO: RESULT <= RESULT + lower 32 bits of A*B (unsigned, wraps modulo 2^32), one cycle after the CONTROL write ack; sets DONE.
  - CLR: RESULT <= 0 and DONE <= 0.
  - GO and CLR in the same write: CLR wins.
- File FIFOs:
  - file_write pushes into FIFO file_num; a push to a full FIFO is dropped.
  - file_read pops; file_read_data is registered and valid the cycle after the request, with file_active=1 for exactly that cycle.
  - Read of an empty FIFO returns 0.
  - Simultaneous read+write on the same FIFO performs both; the read returns the oldest word, and when empty returns 0 while the write is stored.
  - file_active pulses for any read/write request, including ignored file_num values.
- Reset asserted mid-transaction aborts it immediately: active=0, bus idle, FIFOs emptied.

Decomposition:
- Shared package dsp_pkg:
  - address constants (MEM_BASE, DSP_CONTROL, DSP_A, DSP_B, DSP_RESULT, DSP_STATUS, DSP_DTB);
  - CONTROL bit positions;
  - the 32-bit data/address widths.
- One natural sub-module: wb_cmd_master, instantiated twice for the CPU and DAQ ports.
- Arbiter, slaves and FIFOs are inline.

Test Plan:
- CPU write 0x1234_5678 to 0x10 with sel=0xF, then read 0x10 -> cpu_data_rd=0x1234_5678; active high for 2 cycles each.
- Write sel=0x1 of 0xFFFF_FFAA to 0x10 -> read returns 0x1234_56AA.
- Simultaneous cpu_start (write 0x1 to 0x20) and daq_start (read 0x20) -> CPU finishes first; DAQ reads 0x0000_0001.
- A=3, B=5, GO twice -> RESULT=30, DONE=1; then CLR -> RESULT=0, STATUS=0. A=0xFFFF_FFFF, B=2, GO -> RESULT=0xFFFF_FFFE.
- Write 0xCAFE_F00D to DTB -> dtb_pad=0xCAFE_F00D the cycle after ack. Read 0x2000 -> returns 0.
- Push 9 words 1..9 to file 2, then pop 9 times -> returns 1..8, then 0; file 1 stays empty; file_active pulses once per request.
